obstacle_scheduler: RTL and testbench

Consumer stage for the `random` block. Requests a fresh random word and turns it into a spawn gap and an obstacle type. Counts down the gap in frame ticks, then spawns the obstacle into a fixed pool of on-screen slots. Scrolls every live slot left each tick and hands positions and types to the renderer and collision logic.

---
 rtl/dino_pkg.sv | 29 ++
 rtl/obstacle_slot.sv | 61 ++++++
 rtl/obstacle_scheduler.sv | 143 ++++++++++++++
 tb/tb_obstacle_scheduler.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/dino_pkg.sv
// Shared definitions for the dino game obstacle path: obstacle types,
// scheduler state encoding and screen constants used by the renderer.
package dino_pkg;

    typedef enum logic [1:0] {
        SMALL_CACTUS = 2'd0,
        LARGE_CACTUS = 2'd1,
        CACTUS_GROUP = 2'd2,
        BIRD         = 2'd3
    } obstacle_t;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_REQ      = 3'd1;
    localparam logic [2:0] ST_LATCH    = 3'd2;
    localparam logic [2:0] ST_WAIT_GAP = 3'd3;
    localparam logic [2:0] ST_SPAWN    = 3'd4;

    localparam int SCREEN_W     = 640;
    localparam int SCROLL_SPEED = 4;
    localparam int X_COORD_W    = 10;

    // Gap counter width: enough for the largest gap, never narrower than a byte.
    function automatic int gap_width(input int max_gap);
        int w = 1;
        while ((1 << w) <= max_gap) w++;
        return (w < 8) ? 8 : w;
    endfunction

endpackage

// File: rtl/obstacle_slot.sv
// One on-screen obstacle: live flag, x position and type, with the
// scroll-left / expire-at-left-edge rule applied on each scroll tick.
module obstacle_slot
    import dino_pkg::*;
#(
    parameter int X_W      = X_COORD_W,
    parameter int SCREEN_X = SCREEN_W,
    parameter int SPEED    = SCROLL_SPEED
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           clear_i,
    input  logic           load_i,
    input  logic [1:0]     load_type_i,
    input  logic           tick_scroll_i,
    output logic           valid_o,
    output logic [X_W-1:0] x_o,
    output logic [1:0]     type_o
);

    localparam logic [X_W-1:0] SPAWN_X = X_W'(SCREEN_X);
    localparam logic [X_W-1:0] SPEED_X = X_W'(SPEED);

    logic           valid_q, valid_d;
    logic [X_W-1:0] x_q, x_d;
    obstacle_t      type_q, type_d;

    // A load wins over scrolling so a freshly spawned obstacle appears at SCREEN_X.
    always_comb begin
        valid_d = valid_q;
        x_d     = x_q;
        type_d  = type_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            x_d     = SPAWN_X;
            type_d  = obstacle_t'(load_type_i);
        end else if (tick_scroll_i && valid_q) begin
            if (x_q < SPEED_X) valid_d = 1'b0;
            else               x_d     = x_q - SPEED_X;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            x_q     <= '0;
            type_q  <= SMALL_CACTUS;
        end else begin
            valid_q <= valid_d;
            x_q     <= x_d;
            type_q  <= type_d;
        end
    end

    assign valid_o = valid_q;
    assign x_o     = x_q;
    assign type_o  = type_q;

endmodule

// File: rtl/obstacle_scheduler.sv
// Obstacle scheduler: requests a random word, waits out the spawn gap in
// frame ticks, then places the obstacle in the lowest free slot of the pool.
//
// state    | meaning
// IDLE     | game stopped; slots frozen for the game-over screen
// REQ      | rand_start high, random block registers a new word
// LATCH    | random word valid; load gap counter and pending type
// WAIT_GAP | count ticks down to zero
// SPAWN    | load pending obstacle into lowest free slot (waits if pool full)
module obstacle_scheduler
    import dino_pkg::*;
#(
    parameter int NUM_LEN    = 4,
    parameter int RAND_COUNT = 2,
    parameter int SLOTS      = 4,
    parameter int X_W        = X_COORD_W,
    parameter int SCREEN_X   = SCREEN_W,
    parameter int SPEED      = SCROLL_SPEED,
    parameter int MIN_GAP    = 16,
    parameter int GAP_SCALE  = 2
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          run,
    input  logic                          tick,
    input  logic [NUM_LEN*RAND_COUNT-1:0] randoms,
    output logic                          rand_start,
    output logic [SLOTS-1:0]              obj_valid,
    output logic [SLOTS*X_W-1:0]          obj_x,
    output logic [SLOTS*2-1:0]            obj_type,
    output logic                          spawn_pulse
);

    localparam int GAP_MAX = MIN_GAP + ((1 << NUM_LEN) - 1) * GAP_SCALE;
    localparam int GAP_W   = gap_width(GAP_MAX);

    logic [2:0]         state_q, state_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    obstacle_t          pend_q, pend_d;
    logic [NUM_LEN-1:0] field0;
    logic [1:0]         field1_type;
    logic [SLOTS-1:0]   free_onehot;
    logic [SLOTS-1:0]   load_vec;
    logic               free_any;
    logic               clear_all;
    logic               tick_scroll;
    logic               unused_rand_bits;

    assign field0           = randoms[NUM_LEN-1:0];
    assign field1_type      = randoms[NUM_LEN+1:NUM_LEN];
    assign unused_rand_bits = ^randoms[NUM_LEN*RAND_COUNT-1:NUM_LEN+2];
    assign tick_scroll      = run & tick;

    always_comb begin
        free_onehot = '0;
        free_any    = 1'b0;
        for (int i = 0; i < SLOTS; i++) begin
            if (!obj_valid[i] && !free_any) begin
                free_onehot[i] = 1'b1;
                free_any       = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        gap_d       = gap_q;
        pend_d      = pend_q;
        clear_all   = 1'b0;
        load_vec    = '0;
        spawn_pulse = 1'b0;
        rand_start  = 1'b0;
        if (state_q == ST_IDLE) begin
            if (run) begin
                clear_all = 1'b1;
                state_d   = ST_REQ;
            end
        end else if (!run) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_REQ: begin
                    rand_start = 1'b1;
                    state_d    = ST_LATCH;
                end
                ST_LATCH: begin
                    gap_d   = GAP_W'(MIN_GAP) + GAP_W'(field0) * GAP_W'(GAP_SCALE);
                    pend_d  = obstacle_t'(field1_type);
                    state_d = ST_WAIT_GAP;
                end
                ST_WAIT_GAP: begin
                    if (gap_q == '0) begin
                        state_d = ST_SPAWN;
                    end else if (tick) begin
                        gap_d = gap_q - GAP_W'(1);
                        if (gap_q == GAP_W'(1)) state_d = ST_SPAWN;
                    end
                end
                ST_SPAWN: begin
                    // Free flags come from registered valids, so a slot expiring on
                    // this cycle's tick is only usable next cycle.
                    if (free_any) begin
                        load_vec    = free_onehot;
                        spawn_pulse = 1'b1;
                        state_d     = ST_REQ;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            gap_q   <= '0;
            pend_q  <= SMALL_CACTUS;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            pend_q  <= pend_d;
        end
    end

    for (genvar g = 0; g < SLOTS; g++) begin : g_slot
        obstacle_slot #(
            .X_W      (X_W),
            .SCREEN_X (SCREEN_X),
            .SPEED    (SPEED)
        ) u_slot (
            .clock         (clock),
            .reset         (reset),
            .clear_i       (clear_all),
            .load_i        (load_vec[g]),
            .load_type_i   (pend_q),
            .tick_scroll_i (tick_scroll),
            .valid_o       (obj_valid[g]),
            .x_o           (obj_x[g*X_W +: X_W]),
            .type_o        (obj_type[g*2 +: 2])
        );
    end

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Directed bench for obstacle_scheduler at default parameters.
module tb_obstacle_scheduler;

    logic        clock;
    logic        reset;
    logic        run;
    logic        tick;
    logic [7:0]  randoms;
    logic        rand_start;
    logic [3:0]  obj_valid;
    logic [39:0] obj_x;
    logic [7:0]  obj_type;
    logic        spawn_pulse;

    int checks   = 0;
    int failures = 0;

    obstacle_scheduler dut (
        .clock       (clock),
        .reset       (reset),
        .run         (run),
        .tick        (tick),
        .randoms     (randoms),
        .rand_start  (rand_start),
        .obj_valid   (obj_valid),
        .obj_x       (obj_x),
        .obj_type    (obj_type),
        .spawn_pulse (spawn_pulse)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    function automatic logic [9:0] sx(input int i);
        return obj_x[i*10 +: 10];
    endfunction

    // One clock cycle with the given tick level; returns at the next falling edge.
    task automatic cyc(input logic t);
        tick = t;
        @(negedge clock);
        tick = 1'b0;
    endtask

    task automatic apply_reset();
        run     = 1'b0;
        tick    = 1'b0;
        randoms = 8'h00;
        reset   = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        run     = 1'b0;
        tick    = 1'b0;
        randoms = 8'h00;
        reset   = 1'b0;
        repeat (2) @(negedge clock);
        checks++; if (obj_valid !== 4'b0000) begin failures++; $display("FAIL rst_valid got=%b exp=0000", obj_valid); end
        checks++; if (obj_x !== 40'd0) begin failures++; $display("FAIL rst_x got=%h exp=0", obj_x); end
        checks++; if (obj_type !== 8'd0) begin failures++; $display("FAIL rst_type got=%h exp=0", obj_type); end
        checks++; if (rand_start !== 1'b0) begin failures++; $display("FAIL rst_rand_start got=%b exp=0", rand_start); end
        checks++; if (spawn_pulse !== 1'b0) begin failures++; $display("FAIL rst_spawn got=%b exp=0", spawn_pulse); end
        reset = 1'b1;
        cyc(1'b0);
        checks++; if (rand_start !== 1'b0) begin failures++; $display("FAIL idle_hold_rand_start got=%b exp=0", rand_start); end
    endtask

    task automatic test_first_spawn();
        randoms = 8'h35;
        run     = 1'b1;
        checks++; if (rand_start !== 1'b0) begin failures++; $display("FAIL rs_before got=%b exp=0", rand_start); end
        cyc(1'b0);
        checks++; if (rand_start !== 1'b1) begin failures++; $display("FAIL rs_pulse got=%b exp=1", rand_start); end
        cyc(1'b0);
        checks++; if (rand_start !== 1'b0) begin failures++; $display("FAIL rs_one_cycle got=%b exp=0", rand_start); end
        cyc(1'b0);
        repeat (25) cyc(1'b1);
        checks++; if (spawn_pulse !== 1'b0) begin failures++; $display("FAIL no_early_spawn got=%b exp=0", spawn_pulse); end
        cyc(1'b1);
        checks++; if (spawn_pulse !== 1'b1) begin failures++; $display("FAIL spawn_after_26 got=%b exp=1", spawn_pulse); end
        cyc(1'b0);
        checks++; if (obj_valid !== 4'b0001) begin failures++; $display("FAIL first_valid got=%b exp=0001", obj_valid); end
        checks++; if (sx(0) !== 10'd640) begin failures++; $display("FAIL first_x got=%0d exp=640", sx(0)); end
        checks++; if (obj_type[1:0] !== 2'd3) begin failures++; $display("FAIL first_type got=%0d exp=3", obj_type[1:0]); end
        checks++; if (spawn_pulse !== 1'b0) begin failures++; $display("FAIL spawn_one_cycle got=%b exp=0", spawn_pulse); end
    endtask

    task automatic test_expiry();
        repeat (159) cyc(1'b1);
        checks++; if (sx(0) !== 10'd4) begin failures++; $display("FAIL exp_x159 got=%0d exp=4", sx(0)); end
        checks++; if (obj_valid[0] !== 1'b1) begin failures++; $display("FAIL exp_v159 got=%b exp=1", obj_valid[0]); end
        cyc(1'b1);
        checks++; if (sx(0) !== 10'd0) begin failures++; $display("FAIL exp_x160 got=%0d exp=0", sx(0)); end
        checks++; if (obj_valid[0] !== 1'b1) begin failures++; $display("FAIL exp_v160 got=%b exp=1", obj_valid[0]); end
        cyc(1'b1);
        checks++; if (obj_valid[0] !== 1'b0) begin failures++; $display("FAIL exp_v161 got=%b exp=0", obj_valid[0]); end
    endtask

    task automatic test_fill_lowest();
        int n;
        logic [3:0] mask;
        apply_reset();
        randoms = 8'h00;
        run     = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (!spawn_pulse && n < 60) begin
                cyc(1'b1);
                n++;
            end
            checks++; if (n != ((k == 0) ? 19 : 18)) begin failures++; $display("FAIL fill_gap slot=%0d got=%0d exp=%0d", k, n, (k == 0) ? 19 : 18); end
            cyc(1'b1);
            mask = 4'((1 << (k + 1)) - 1);
            checks++; if (obj_valid !== mask) begin failures++; $display("FAIL fill_valid slot=%0d got=%b exp=%b", k, obj_valid, mask); end
            checks++; if (sx(k) !== 10'd640) begin failures++; $display("FAIL fill_new_x slot=%0d got=%0d exp=640", k, sx(k)); end
            checks++; if (sx(0) !== 10'(640 - 76 * k)) begin failures++; $display("FAIL fill_slot0_x k=%0d got=%0d exp=%0d", k, sx(0), 640 - 76 * k); end
        end
    endtask

    task automatic test_pool_full();
        int n;
        n = 0;
        while (!spawn_pulse && n < 200) begin
            cyc(1'b1);
            n++;
        end
        checks++; if (n != 104) begin failures++; $display("FAIL full_hold_cycles got=%0d exp=104", n); end
        checks++; if (obj_valid !== 4'b1110) begin failures++; $display("FAIL full_freed got=%b exp=1110", obj_valid); end
        cyc(1'b1);
        checks++; if (obj_valid !== 4'b1111) begin failures++; $display("FAIL full_refill got=%b exp=1111", obj_valid); end
        checks++; if (sx(0) !== 10'd640) begin failures++; $display("FAIL full_refill_x got=%0d exp=640", sx(0)); end
    endtask

    task automatic test_freeze();
        apply_reset();
        randoms = 8'h00;
        run     = 1'b1;
        repeat (3) cyc(1'b0);
        randoms = 8'h2F;
        repeat (16) cyc(1'b1);
        cyc(1'b0);
        repeat (2) cyc(1'b0);
        repeat (46) cyc(1'b1);
        checks++; if (spawn_pulse !== 1'b1) begin failures++; $display("FAIL frz_gap46 got=%b exp=1", spawn_pulse); end
        cyc(1'b0);
        repeat (2) cyc(1'b0);
        repeat (20) cyc(1'b1);
        run = 1'b0;
        cyc(1'b1);
        repeat (20) cyc(1'b1);
        checks++; if (sx(0) !== 10'd376) begin failures++; $display("FAIL frz_x0 got=%0d exp=376", sx(0)); end
        checks++; if (sx(1) !== 10'd560) begin failures++; $display("FAIL frz_x1 got=%0d exp=560", sx(1)); end
        checks++; if (obj_valid !== 4'b0011) begin failures++; $display("FAIL frz_valid got=%b exp=0011", obj_valid); end
        checks++; if (obj_type !== 8'h08) begin failures++; $display("FAIL frz_type got=%h exp=08", obj_type); end
        checks++; if (rand_start !== 1'b0) begin failures++; $display("FAIL frz_rand_start got=%b exp=0", rand_start); end
        run = 1'b1;
        cyc(1'b0);
        checks++; if (obj_valid !== 4'b0000) begin failures++; $display("FAIL rerun_clear got=%b exp=0000", obj_valid); end
        checks++; if (rand_start !== 1'b1) begin failures++; $display("FAIL rerun_req got=%b exp=1", rand_start); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        randoms = 8'h00;
        run     = 1'b1;
        repeat (3) cyc(1'b0);
        repeat (16) cyc(1'b1);
        cyc(1'b0);
        repeat (2) cyc(1'b0);
        repeat (16) cyc(1'b1);
        checks++; if (spawn_pulse !== 1'b1 || obj_valid !== 4'b0001) begin failures++; $display("FAIL ar_precond got=%b/%b exp=1/0001", spawn_pulse, obj_valid); end
        #2 reset = 1'b0;
        #1;
        checks++; if (obj_valid !== 4'b0000) begin failures++; $display("FAIL ar_valid got=%b exp=0000", obj_valid); end
        checks++; if (obj_x !== 40'd0) begin failures++; $display("FAIL ar_x got=%h exp=0", obj_x); end
        checks++; if (spawn_pulse !== 1'b0) begin failures++; $display("FAIL ar_spawn got=%b exp=0", spawn_pulse); end
        @(negedge clock);
        reset = 1'b1;
        cyc(1'b0);
        checks++; if (rand_start !== 1'b1) begin failures++; $display("FAIL ar_idle_restart got=%b exp=1", rand_start); end
        checks++; if (obj_valid !== 4'b0000) begin failures++; $display("FAIL ar_no_spawn got=%b exp=0000", obj_valid); end
    endtask

    initial begin
        reset   = 1'b0;
        run     = 1'b0;
        tick    = 1'b0;
        randoms = 8'h00;
        test_reset();
        test_first_spawn();
        test_expiry();
        test_fill_lowest();
        test_pool_full();
        test_freeze();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
